// File: rtl/btn_pkg.sv
// btn_pkg: shared types and width helpers for the button debouncer
//   btn_state_t : per-button debounce FSM state (RELEASED = 0)
//   cnt_w()     : counter width able to hold 0..n-1, never below 1 bit
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } btn_state_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button pins in, debounced levels and strobes out
//   btn_raw     : asynchronous pin levels
//   btn_level   : debounced state, 1 = pressed
//   btn_press   : 1-cycle strobe on accepted press
//   btn_release : 1-cycle strobe on accepted release
//   btn_repeat  : 1-cycle auto-repeat strobe while held
//   master = board/consumer side, slave = debouncer side
interface btn_debounce_if #(
    parameter int N_BTN = 7
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (output btn_raw, input btn_level, btn_press, btn_release, btn_repeat);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button's debounce FSM, debounce counter and optional repeat counter
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : synchronised, polarity-normalised input (1 = pressed)
//   level      : debounced level
//   press/rel  : registered 1-cycle strobes on accepted press/release
//   rpt        : registered auto-repeat strobe (tied 0 unless BTN_DEBOUNCE_REPEAT_EN)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 100000,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("btn_debounce_ch: invalid DB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // Any disagreeing sample in a pending state drops back to the stable state:
    // the count always restarts from zero, there is no partial credit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            RELEASED: if (s) begin
                state_d = PRESS_PEND;
                cnt_d   = CW'(1);
            end
            PRESS_PEND: if (!s) begin
                state_d = RELEASED;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = PRESSED;
                cnt_d   = '0;
                level_d = 1'b1;
                press_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            PRESSED: if (!s) begin
                state_d = REL_PEND;
                cnt_d   = CW'(1);
            end
            REL_PEND: if (s) begin
                state_d = PRESSED;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
                rel_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_q, rpt_d;

    // Counter holds cycles since press; after a pulse it is rewound so the
    // next terminal count comes REPEAT_PERIOD cycles later. The release edge
    // itself wins over a coincident repeat.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_d     = 1'b0;
        if (state_q inside {PRESSED, REL_PEND} && !rel_d) begin
            rpt_d     = (rpt_cnt_q == RPT_LAST);
            rpt_cnt_d = rpt_d ? RPT_RELOAD : rpt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, polarity-normalise and debounce N_BTN push-buttons
//   clk, rst_n : PLL clock, asynchronous active-low reset
//   bus        : btn_debounce_if.slave (btn_raw in; level/press/release/repeat out)
//   Optional auto-repeat enabled by defining BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 7,
    parameter int               DB_CYCLES       = 100000,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
    parameter int               REPEAT_DELAY    = 5000000,
    parameter int               REPEAT_PERIOD   = 1000000
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);
    logic [N_BTN-1:0] sync1_q, sync2_q, s;
    logic [N_BTN-1:0] level, press, rel, rpt;

    // Sync flops reset to the idle (not-pressed) pin level so no phantom
    // press is seen on the active-low button after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW_MASK;
            sync2_q <= ACTIVE_LOW_MASK;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .s    (s[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i]),
            .rpt  (rpt[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_repeat  = rpt;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: self-checking bench for btn_debounce (DB=8, REPEAT 20/5)
module tb_btn_debounce;
    localparam int         N    = 7;
    localparam int         DB   = 8;
    localparam int         RD   = 20;
    localparam int         RP   = 5;
    localparam logic [6:0] MASK = 7'h01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_if #(.N_BTN(N)) bus ();

    btn_debounce #(
        .N_BTN          (N),
        .DB_CYCLES      (DB),
        .ACTIVE_LOW_MASK(MASK),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [6:0] lvl;
        logic [6:0] prs;
        logic [6:0] rel;
        logic [6:0] rpt;
    } out_t;

    typedef struct {
        logic [6:0] raw;
        int         n;
        logic [6:0] lvl;
    } seg_t;

    out_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc_no = 0;
    int         rpt_total = 0;
    logic [6:0] m_d1 = MASK;
    logic [6:0] m_d2 = MASK;
    logic [6:0] m_lvl = '0;
    int         m_run[7];
    int         m_hold[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc_no, got, exp);
        end
    endtask

    // Reference: count consecutive samples that disagree with the accepted
    // level; DB of them in a row flips the level.
    task automatic model_step(input logic rst, input logic [6:0] raw, output out_t o);
        logic [6:0] s;
        logic       old;
        o = '0;
        if (!rst) begin
            m_d1  = MASK;
            m_d2  = MASK;
            m_lvl = '0;
            for (int b = 0; b < N; b++) begin
                m_run[b]  = 0;
                m_hold[b] = 0;
            end
        end else begin
            s    = m_d2 ^ MASK;
            m_d2 = m_d1;
            m_d1 = raw;
            for (int b = 0; b < N; b++) begin
                old = m_lvl[b];
                if (s[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_run[b] = 0;
                        m_lvl[b] = ~m_lvl[b];
                        if (m_lvl[b]) o.prs[b] = 1'b1;
                        else o.rel[b] = 1'b1;
                    end
                end else begin
                    m_run[b] = 0;
                end
`ifdef BTN_DEBOUNCE_REPEAT_EN
                if (o.prs[b] || o.rel[b]) m_hold[b] = 0;
                else if (old) begin
                    m_hold[b]++;
                    if (m_hold[b] >= RD && (m_hold[b] - RD) % RP == 0) o.rpt[b] = 1'b1;
                end
`else
                m_hold[b] = old ? m_hold[b] : 0;
`endif
            end
            o.lvl = m_lvl;
        end
    endtask

    task automatic cyc(input logic rst, input logic [6:0] raw);
        out_t e;
        out_t g;
        @(negedge clk);
        rst_n       = rst;
        bus.btn_raw = raw;
        model_step(rst, raw, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        e = exp_q.pop_front();
        g = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
        rpt_total += $countones(bus.btn_repeat);
        chk("level", 32'(g.lvl), 32'(e.lvl));
        chk("press", 32'(g.prs), 32'(e.prs));
        chk("release", 32'(g.rel), 32'(e.rel));
        chk("repeat", 32'(g.rpt), 32'(e.rpt));
        chk("press_and_release", 32'(bus.btn_press & bus.btn_release), 32'd0);
        chk("press_and_repeat", 32'(bus.btn_press & bus.btn_repeat), 32'd0);
    endtask

    task automatic run(input logic [6:0] raw, input int n);
        repeat (n) cyc(1'b1, raw);
    endtask

    // Returns the cycle (1-based) on which the selected strobe of button idx
    // first appears, or 0 if it never does within limit cycles.
    task automatic wait_evt(input logic [6:0] raw, input int idx, input int sel,
                            input int limit, output int n);
        logic [6:0] v;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            cyc(1'b1, raw);
            v = (sel == 0) ? bus.btn_press : (sel == 1) ? bus.btn_release : bus.btn_repeat;
            if (v[idx]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        seg_t segs[16];
        int   n;
        int   snap;
        segs = '{
            '{7'h01, 50, 7'h00},
            '{7'h09, 12, 7'h08},
            '{7'h01, 12, 7'h00},
            '{7'h00, 12, 7'h01},
            '{7'h01, 12, 7'h00},
            '{7'h05,  5, 7'h00},
            '{7'h01,  1, 7'h00},
            '{7'h05,  7, 7'h00},
            '{7'h01, 12, 7'h00},
            '{7'h05,  5, 7'h00},
            '{7'h01,  1, 7'h00},
            '{7'h05,  8, 7'h00},
            '{7'h01,  3, 7'h04},
            '{7'h01, 12, 7'h00},
            '{7'h23, 12, 7'h22},
            '{7'h01, 12, 7'h00}
        };
        bus.btn_raw = MASK;
        rst_n       = 1'b0;
        repeat (3) cyc(1'b0, MASK);
        chk("reset_all_out", 32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat}), 32'd0);

        for (int i = 0; i < 16; i++) begin
            run(segs[i].raw, segs[i].n);
            chk($sformatf("seg%0d_level", i), 32'(bus.btn_level), 32'(segs[i].lvl));
        end

        wait_evt(7'h09, 3, 0, 30, n);
        chk("press3_latency", n, 10);
        chk("press3_level", 32'(bus.btn_level[3]), 32'd1);
        cyc(1'b1, 7'h09);
        chk("press3_width", 32'(bus.btn_press[3]), 32'd0);
        run(7'h09, 3);
        wait_evt(7'h01, 3, 1, 30, n);
        chk("release3_latency", n, 10);

        wait_evt(7'h00, 0, 0, 30, n);
        chk("press0_active_low_latency", n, 10);
        chk("press0_level", 32'(bus.btn_level[0]), 32'd1);
        run(7'h01, 12);

        wait_evt(7'h23, 1, 0, 30, n);
        chk("press1_latency", n, 10);
        chk("press5_same_cycle", 32'(bus.btn_press[5]), 32'd1);
        run(7'h01, 12);

        run(7'h11, 5);
        cyc(1'b0, 7'h11);
        cyc(1'b0, 7'h11);
        run(7'h01, 15);
        chk("rst_abort_level4", 32'(bus.btn_level[4]), 32'd0);

        run(7'h11, 5);
        cyc(1'b0, 7'h11);
        wait_evt(7'h11, 4, 0, 30, n);
        chk("rst_held_latency4", n, 10);
        run(7'h01, 12);

`ifdef BTN_DEBOUNCE_REPEAT_EN
        begin
            int offs[$];
            int exp_offs[4];
            exp_offs = '{20, 25, 30, 35};
            wait_evt(7'h41, 6, 0, 30, n);
            chk("press6_latency", n, 10);
            for (int i = 1; i <= 39; i++) begin
                cyc(1'b1, 7'h41);
                if (bus.btn_repeat[6]) offs.push_back(i);
            end
            chk("rpt6_count", offs.size(), 4);
            for (int j = 0; j < 4; j++)
                chk($sformatf("rpt6_offset%0d", j), (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
            wait_evt(7'h01, 6, 1, 30, n);
            chk("release6_latency", n, 10);
            snap = rpt_total;
            run(7'h01, 20);
            chk("rpt6_after_release", rpt_total - snap, 0);
        end
`else
        snap = 0;
        run(7'h41, 40);
        run(7'h01, 12);
        chk("rpt_tied_zero", rpt_total - snap, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
